// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between PORTS requesters.
// Optional response watchdog is compiled in with the ARB_TIMEOUT_EN macro.
module mem_port_arbiter #(
  parameter int PORTS          = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              req_valid,
  output logic [PORTS-1:0]              req_ready,
  input  logic [PORTS-1:0]              req_we,
  input  logic [PORTS*ADDR_W-1:0]       req_addr,
  input  logic [PORTS*DATA_W-1:0]       req_wdata,
  input  logic [PORTS*(DATA_W/8)-1:0]   req_wstrb,
  output logic [PORTS-1:0]              resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_wstrb,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic [$clog2(PORTS)-1:0]      grant_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = $clog2(PORTS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   grant_id_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic [PORTS-1:0]  resp_valid_reg;
  logic [DATA_W-1:0] resp_rdata_reg;

  logic              any_valid;
  logic [ID_W-1:0]   winner_id;
  logic [ID_W-1:0]   rr_ptr_next;
  logic              grant_fire;
  logic              rsp_fire;
  logic              timeout_fire;

  logic [ADDR_W-1:0] addr_arr  [PORTS];
  logic [DATA_W-1:0] wdata_arr [PORTS];
  logic [STRB_W-1:0] wstrb_arr [PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
    end
  endgenerate

  // Walk downward from the farthest offset so the nearest valid port at or after rr_ptr wins.
  always_comb begin
    logic [ID_W:0] rot_idx;
    any_valid = 1'b0;
    winner_id = '0;
    rot_idx   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      rot_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (rot_idx >= (ID_W+1)'(PORTS)) rot_idx = rot_idx - (ID_W+1)'(PORTS);
      if (req_valid[rot_idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner_id = rot_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    logic [ID_W:0] inc_idx;
    inc_idx = {1'b0, winner_id} + (ID_W+1)'(1);
    if (inc_idx >= (ID_W+1)'(PORTS)) inc_idx = inc_idx - (ID_W+1)'(PORTS);
    rr_ptr_next = inc_idx[ID_W-1:0];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             resp_err_reg;
  logic             wait_limit;

  // Last WAIT cycle before the limit is reached; rvalid in this cycle still wins.
  assign wait_limit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_ISSUE && mem_ready) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_reg <= 1'b0;
    end else if (rsp_fire) begin
      resp_err_reg <= 1'b0;
    end else if (timeout_fire) begin
      resp_err_reg <= 1'b1;
    end
  end

  assign resp_err = resp_err_reg;
`else
  logic wait_limit;
  assign wait_limit = 1'b0;
  assign resp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    req_ready    = '0;
    grant_fire   = 1'b0;
    rsp_fire     = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (any_valid) begin
          req_ready[winner_id] = 1'b1;
          grant_fire           = 1'b1;
          state_next           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rsp_fire   = 1'b1;
          state_next = S_IDLE;
        end else if (wait_limit) begin
          timeout_fire = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      grant_id_reg   <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      resp_valid_reg <= '0;
      resp_rdata_reg <= '0;
    end else begin
      resp_valid_reg <= '0;
      if (grant_fire) begin
        we_reg       <= req_we[winner_id];
        addr_reg     <= addr_arr[winner_id];
        wdata_reg    <= wdata_arr[winner_id];
        wstrb_reg    <= wstrb_arr[winner_id];
        grant_id_reg <= winner_id;
        rr_ptr_reg   <= rr_ptr_next;
      end
      if (rsp_fire) begin
        resp_valid_reg[grant_id_reg] <= 1'b1;
        resp_rdata_reg               <= mem_rdata;
      end else if (timeout_fire) begin
        resp_valid_reg[grant_id_reg] <= 1'b1;
        resp_rdata_reg               <= '0;
      end
    end
  end

  assign mem_valid  = (state_reg == S_ISSUE);
  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wstrb  = wstrb_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign busy       = (state_reg != S_IDLE);
  assign grant_id   = grant_id_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (PORTS=2, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
  localparam int PORTS = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [PORTS-1:0]    req_valid;
  logic [PORTS-1:0]    req_ready;
  logic [PORTS-1:0]    req_we;
  logic [PORTS*AW-1:0] req_addr;
  logic [PORTS*DW-1:0] req_wdata;
  logic [PORTS*SW-1:0] req_wstrb;
  logic [PORTS-1:0]    resp_valid;
  logic [DW-1:0]       resp_rdata;
  logic                resp_err;
  logic                mem_valid;
  logic                mem_ready;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [SW-1:0]       mem_wstrb;
  logic                mem_rvalid;
  logic [DW-1:0]       mem_rdata;
  logic                busy;
  logic                grant_id;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;

  mem_port_arbiter #(
    .PORTS(PORTS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_valid && mem_ready) accept_cnt <= accept_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full read transaction for port exp_id while req_valid stays asserted.
  task automatic serve(input int exp_id, input logic [31:0] data);
    logic [1:0] onehot;
    onehot = 2'b01 << exp_id;
    #1;
    check("rr_ready", 128'(req_ready), 128'(onehot));
    tick();
    check("rr_grant_id", 128'(grant_id), 128'(exp_id));
    check("rr_mem_valid", 128'(mem_valid), 128'(1'b1));
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    check("rr_resp_valid", 128'(resp_valid), 128'(onehot));
    check("rr_resp_rdata", 128'(resp_rdata), 128'(data));
  endtask

  initial begin
    int acc0;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mem_valid", 128'(mem_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_err", 128'(resp_err), 128'(0));
    check("rst_grant_id", 128'(grant_id), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));

    // Single read from port 0.
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h0000_0100;
    #1;
    check("t1_req_ready", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = '0;
    check("t1_mem_valid", 128'(mem_valid), 128'(1));
    check("t1_mem_addr", 128'(mem_addr), 128'(32'h100));
    check("t1_mem_we", 128'(mem_we), 128'(0));
    check("t1_busy", 128'(busy), 128'(1));
    check("t1_ready_low", 128'(req_ready), 128'(0));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t1_mem_valid_off", 128'(mem_valid), 128'(0));
    tick();
    check("t1_no_early_resp", 128'(resp_valid), 128'(0));
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("t1_resp_valid", 128'(resp_valid), 128'(2'b01));
    check("t1_resp_rdata", 128'(resp_rdata), 128'(32'hDEAD_BEEF));
    check("t1_resp_err", 128'(resp_err), 128'(0));
    check("t1_busy_idle", 128'(busy), 128'(0));
    tick();
    check("t1_pulse_end", 128'(resp_valid), 128'(0));
    check("t1_rdata_hold", 128'(resp_rdata), 128'(32'hDEAD_BEEF));

    // Backpressured write from port 1.
    req_valid = 2'b10; req_we = 2'b10; req_addr[AW +: AW] = 32'h2000_0040;
    req_wdata[DW +: DW] = 32'h1234_5678; req_wstrb[SW +: SW] = 4'b0011;
    #1;
    check("bp_req_ready", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid = '0; req_we = '0;
    acc0 = accept_cnt;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_ready = 1'b1;
      check("bp_fields", {mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb},
            {1'b1, 1'b1, 32'h2000_0040, 32'h1234_5678, 4'b0011});
      tick();
    end
    mem_ready = 1'b0;
    check("bp_one_accept", 128'(accept_cnt - acc0), 128'(1));
    check("bp_wait_valid", 128'(mem_valid), 128'(0));
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_rvalid = 1'b0;
    check("bp_resp_valid", 128'(resp_valid), 128'(2'b10));
    check("bp_grant_id", 128'(grant_id), 128'(1));

    // Reset while in WAIT, after a port-0 grant moved the pointer to 1.
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h0000_0200;
    tick();
    req_valid = '0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("rw_busy_wait", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    check("rw_busy_rst", 128'(busy), 128'(0));
    tick();
    mem_rvalid = 1'b0;
    check("rw_no_resp", 128'(resp_valid), 128'(0));
    check("rw_busy_after", 128'(busy), 128'(0));

    // Contention: both ports continuously requesting, pointer restarted at 0.
    req_valid = 2'b11;
    serve(0, 32'hA000_0000);
    serve(1, 32'hA000_0001);
    serve(0, 32'hA000_0002);
    serve(1, 32'hA000_0003);

    // No response from memory.
    req_valid = 2'b01;
    #1;
    check("to_req_ready", 128'(req_ready), 128'(2'b01));
    tick();
    req_valid = '0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check("to_before_limit", 128'(resp_valid), 128'(0));
    check("to_busy_before", 128'(busy), 128'(1));
    tick();
`ifdef ARB_TIMEOUT_EN
    check("to_resp_valid", 128'(resp_valid), 128'(2'b01));
    check("to_resp_err", 128'(resp_err), 128'(1));
    check("to_resp_rdata", 128'(resp_rdata), 128'(0));
    check("to_busy_idle", 128'(busy), 128'(0));
`else
    for (int c = 0; c < 12; c++) tick();
    check("nt_resp_valid", 128'(resp_valid), 128'(0));
    check("nt_busy", 128'(busy), 128'(1));
    check("nt_resp_err", 128'(resp_err), 128'(0));
    check("nt_mem_valid", 128'(mem_valid), 128'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory port (valid/ready request, rvalid response) between PORTS requesters, e.g. instruction fetch and load/store unit.
- Uses round-robin arbitration and captures the winner's request into registers.
- Owns the port until the response returns, then routes the response to the owning requester.
- Sits between the core's fetch/LSU front-ends and the AXI-Lite master bridge.

Parameters:
- PORTS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  PORTS  request valid per requester.
- req_ready  out  PORTS  request accepted, one-hot, combinational.
- req_we  in  PORTS  1 = write.
- req_addr  in  PORTS*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  PORTS*DATA_W  packed write data.
- req_wstrb  in  PORTS*DATA_W/8  packed byte strobes.
- resp_valid  out  PORTS  one-cycle response pulse to the owner.
- resp_rdata  out  DATA_W  read data, shared by all requesters.
- resp_err  out  1  response error flag, qualified by resp_valid.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_wstrb  out  DATA_W/8  strobes.
- mem_rvalid  in  1  memory response (reads and write acks).
- mem_rdata  in  DATA_W  read data.
- busy  out  1  state != IDLE.
- grant_id  out  clog2(PORTS)  index of current/last owner.

Behaviour:
- Reset values:
  - State IDLE; rr pointer 0.
  - mem_valid, resp_valid, resp_err, busy, grant_id and all captured registers are 0.
  - A reset mid-transaction abandons it; a late mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Arbitration searches req_valid circularly starting at the rr pointer; lowest index wins from the pointer onward.
  - If any request is pending, the winner w gets req_ready[w]=1 in that cycle.
  - On that cycle: we/addr/wdata/wstrb are captured, grant_id<=w, rr pointer<=(w+1) mod PORTS, next state ISSUE.
  - req_ready is 0 in ISSUE and WAIT.
- ISSUE:
  - mem_valid=1 with the captured fields, held stable until mem_ready.
  - On mem_valid&mem_ready: next state WAIT.
- WAIT:
  - On mem_rvalid: resp_rdata<=mem_rdata, resp_valid[grant_id]<=1 for exactly one cycle, resp_err<=0, next state IDLE.
  - mem_rvalid is sampled only in WAIT; a same-cycle accept+rvalid in ISSUE is illegal for the memory.
- Latency:
  - req_ready in cycle 0; mem_valid from cycle 1.
  - resp_valid is the cycle after mem_rvalid.
  - Minimum one idle cycle between grants. Because resp_valid coincides with IDLE, the next grant may occur in the resp_valid cycle.
- Arbitration rules:
  - A single continuously requesting port is re-granted every transaction.
  - With all ports requesting, grants rotate 0,1,..,PORTS-1,0.
- Requester rules:
  - A requester must hold req_valid and fields stable until req_ready.
  - Dropping req_valid before grant is permitted and is not an error.
- resp_rdata holds its value until the next response; it is undefined for writes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_rvalid: resp_valid[grant_id] pulses with resp_err=1, resp_rdata=0, next state IDLE.
  - mem_rvalid in the same cycle as the limit wins: normal response, err=0.
- Without the macro: no counter exists, resp_err is tied 0, and WAIT lasts indefinitely.

Test Plan:
- Single read, port 0:
  - Stimulus: addr 0x100; mem_ready immediately; mem_rvalid 2 cycles later with 0xDEADBEEF.
  - Required: mem_valid 1 cycle after req_ready, mem_addr 0x100, resp_valid=2'b01 with rdata 0xDEADBEEF one cycle after rvalid.
- Contention, PORTS=2:
  - Stimulus: both ports request continuously for 4 transactions.
  - Required: grant order 0,1,0,1; resp_valid routed to matching port each time.
- Backpressure:
  - Stimulus: write from port 1 (wdata 0x12345678, wstrb 4'b0011); mem_ready low 5 cycles.
  - Required: mem_valid high and all mem_* fields stable for all 6 cycles; exactly one accept.
- Reset in WAIT:
  - Stimulus: assert rst for 1 cycle in WAIT, then mem_rvalid.
  - Required: no resp_valid, busy=0, next grant starts from port 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: no mem_rvalid.
  - Required: resp_valid with resp_err=1, rdata 0, after 8 WAIT cycles.
  - Without the macro: stays in WAIT, busy=1.
